// File: rtl/snake_body.sv
// Snake segment tracker: advances an ordered segment list each tick and handles
// growth, edge wrap or wall death, self collision and a per-cell occupancy query.
module snake_body #(
    parameter int X_BITS   = 6,
    parameter int Y_BITS   = 5,
    parameter int GRID_W   = 40,
    parameter int GRID_H   = 30,
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 3,
    parameter int WRAP     = 1,
    parameter int LEN_BITS = $clog2(MAX_LEN + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic [1:0]          dir,
    input  logic                grow,
    input  logic [X_BITS-1:0]   query_x,
    input  logic [Y_BITS-1:0]   query_y,
    output logic [X_BITS-1:0]   head_x,
    output logic [Y_BITS-1:0]   head_y,
    output logic [LEN_BITS-1:0] length,
    output logic                query_hit,
    output logic                dead,
    output logic                collide_wall,
    output logic                collide_self
);

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_DOWN  = 2'b10,
        DIR_LEFT  = 2'b11
    } dir_t;

    logic [X_BITS-1:0] seg_x [MAX_LEN];
    logic [Y_BITS-1:0] seg_y [MAX_LEN];
    dir_t              cur_dir;
    dir_t              res_dir;
    logic              grow_pend;
    logic [X_BITS-1:0] nx;
    logic [Y_BITS-1:0] ny;
    logic              wall_hit;
    logic              self_hit;
    logic              grows;

    assign head_x = seg_x[0];
    assign head_y = seg_y[0];

    always_comb begin
        res_dir  = (dir == (cur_dir ^ 2'b10)) ? cur_dir : dir_t'(dir);
        nx       = seg_x[0];
        ny       = seg_y[0];
        wall_hit = 1'b0;
        // Edges are detected by explicit compare so non-power-of-two grids wrap correctly
        unique case (res_dir)
            DIR_UP: begin
                if (seg_y[0] == '0) begin
                    if (WRAP != 0) ny = Y_BITS'(GRID_H - 1);
                    else           wall_hit = 1'b1;
                end else ny = seg_y[0] - Y_BITS'(1);
            end
            DIR_RIGHT: begin
                if (seg_x[0] == X_BITS'(GRID_W - 1)) begin
                    if (WRAP != 0) nx = '0;
                    else           wall_hit = 1'b1;
                end else nx = seg_x[0] + X_BITS'(1);
            end
            DIR_DOWN: begin
                if (seg_y[0] == Y_BITS'(GRID_H - 1)) begin
                    if (WRAP != 0) ny = '0;
                    else           wall_hit = 1'b1;
                end else ny = seg_y[0] + Y_BITS'(1);
            end
            DIR_LEFT: begin
                if (seg_x[0] == '0) begin
                    if (WRAP != 0) nx = X_BITS'(GRID_W - 1);
                    else           wall_hit = 1'b1;
                end else nx = seg_x[0] - X_BITS'(1);
            end
            default: ;
        endcase
    end

    // A grow at full length does not lengthen the body, so the tail still vacates
    always_comb begin
        grows    = (grow_pend | grow) && (length < LEN_BITS'(MAX_LEN));
        self_hit = 1'b0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            if ((LEN_BITS'(i) < length) &&
                (grows || (LEN_BITS'(i) != length - LEN_BITS'(1))) &&
                (seg_x[i] == nx) && (seg_y[i] == ny))
                self_hit = 1'b1;
        end
    end

    always_comb begin
        query_hit = 1'b0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            if ((LEN_BITS'(i) < length) && (seg_x[i] == query_x) && (seg_y[i] == query_y))
                query_hit = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < MAX_LEN; i++) begin
                if (i < INIT_LEN) begin
                    seg_x[i] <= X_BITS'(GRID_W / 2 - i);
                    seg_y[i] <= Y_BITS'(GRID_H / 2);
                end else begin
                    seg_x[i] <= '0;
                    seg_y[i] <= '0;
                end
            end
            cur_dir      <= DIR_RIGHT;
            length       <= LEN_BITS'(INIT_LEN);
            grow_pend    <= 1'b0;
            dead         <= 1'b0;
            collide_wall <= 1'b0;
            collide_self <= 1'b0;
        end else if (!dead) begin
            if (tick) begin
                if (wall_hit) begin
                    dead         <= 1'b1;
                    collide_wall <= 1'b1;
                    grow_pend    <= 1'b0;
                end else if (self_hit) begin
                    dead         <= 1'b1;
                    collide_self <= 1'b1;
                    grow_pend    <= 1'b0;
                end else begin
                    for (int unsigned i = 1; i < MAX_LEN; i++) begin
                        seg_x[i] <= seg_x[i-1];
                        seg_y[i] <= seg_y[i-1];
                    end
                    seg_x[0]  <= nx;
                    seg_y[0]  <= ny;
                    cur_dir   <= res_dir;
                    grow_pend <= 1'b0;
                    if (grows) length <= length + LEN_BITS'(1);
                end
            end else if (grow) begin
                grow_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_snake_body.sv
// Scoreboard bench for snake_body: a queue-based body model predicts the state
// after every stimulus cycle; directed checks cover the wrap, grow and collision cases.
module tb_snake_body;

    localparam int XB = 3;
    localparam int YB = 3;
    localparam int GW = 8;
    localparam int GH = 8;
    localparam int ML = 8;
    localparam int IL = 3;
    localparam int LB = $clog2(ML + 1);

    typedef struct {
        int hx;
        int hy;
        int len;
        int dd;
        int cw;
        int cs;
    } exp_t;

    logic          clk;
    logic          reset;
    logic          tick, grow, w_tick, w_grow;
    logic [1:0]    dir, w_dir;
    logic [XB-1:0] qx, w_qx;
    logic [YB-1:0] qy, w_qy;
    logic [XB-1:0] head_x, w_head_x;
    logic [YB-1:0] head_y, w_head_y;
    logic [LB-1:0] length, w_length;
    logic          query_hit, dead, collide_wall, collide_self;
    logic          w_query_hit, w_dead, w_collide_wall, w_collide_self;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   sel      = 0;
    exp_t exp_q[$];

    int mx[$];
    int my[$];
    int m_dir, m_dead, m_cw, m_cs, m_gp, m_wrap;

    snake_body #(.X_BITS(XB), .Y_BITS(YB), .GRID_W(GW), .GRID_H(GH),
                 .MAX_LEN(ML), .INIT_LEN(IL), .WRAP(1)) dut (
        .clk(clk), .reset(reset), .tick(tick), .dir(dir), .grow(grow),
        .query_x(qx), .query_y(qy), .head_x(head_x), .head_y(head_y),
        .length(length), .query_hit(query_hit), .dead(dead),
        .collide_wall(collide_wall), .collide_self(collide_self)
    );

    snake_body #(.X_BITS(XB), .Y_BITS(YB), .GRID_W(GW), .GRID_H(GH),
                 .MAX_LEN(ML), .INIT_LEN(IL), .WRAP(0)) dut_w (
        .clk(clk), .reset(reset), .tick(w_tick), .dir(w_dir), .grow(w_grow),
        .query_x(w_qx), .query_y(w_qy), .head_x(w_head_x), .head_y(w_head_y),
        .length(w_length), .query_hit(w_query_hit), .dead(w_dead),
        .collide_wall(w_collide_wall), .collide_self(w_collide_self)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset(input int wrap);
        mx.delete();
        my.delete();
        for (int i = 0; i < IL; i++) begin
            mx.push_back(GW / 2 - i);
            my.push_back(GH / 2);
        end
        m_dir = 1; m_dead = 0; m_cw = 0; m_cs = 0; m_gp = 0; m_wrap = wrap;
        exp_q.delete();
    endtask

    task automatic model_step(input int d, input int g, input int tk);
        int rd, nx, ny, lim;
        bit off, grows, hit;
        if (m_dead == 0) begin
            if (tk != 0) begin
                rd  = (d == (m_dir ^ 2)) ? m_dir : d;
                nx  = mx[0] + ((rd == 1) ? 1 : 0) - ((rd == 3) ? 1 : 0);
                ny  = my[0] + ((rd == 2) ? 1 : 0) - ((rd == 0) ? 1 : 0);
                off = (nx < 0) || (nx >= GW) || (ny < 0) || (ny >= GH);
                if (off && m_wrap == 0) begin
                    m_dead = 1; m_cw = 1;
                end else begin
                    nx    = (nx + GW) % GW;
                    ny    = (ny + GH) % GH;
                    grows = ((m_gp != 0) || (g != 0)) && (mx.size() < ML);
                    lim   = grows ? mx.size() : mx.size() - 1;
                    hit   = 1'b0;
                    for (int i = 0; i < lim; i++)
                        if (mx[i] == nx && my[i] == ny) hit = 1'b1;
                    if (hit) begin
                        m_dead = 1; m_cs = 1;
                    end else begin
                        mx.push_front(nx);
                        my.push_front(ny);
                        if (!grows) begin
                            void'(mx.pop_back());
                            void'(my.pop_back());
                        end
                        m_dir = rd;
                        m_gp  = 0;
                    end
                end
            end else if (g != 0) begin
                m_gp = 1;
            end
        end
        exp_q.push_back('{mx[0], my[0], mx.size(), m_dead, m_cw, m_cs});
    endtask

    task automatic check_state();
        exp_t e;
        logic [31:0] hx, hy, ln, dd, cw, cs;
        if (exp_q.size() == 0) begin
            check("sb_empty", 32'd1, 0);
            return;
        end
        e = exp_q.pop_front();
        if (sel == 0) begin
            hx = 32'(head_x); hy = 32'(head_y); ln = 32'(length);
            dd = 32'(dead); cw = 32'(collide_wall); cs = 32'(collide_self);
        end else begin
            hx = 32'(w_head_x); hy = 32'(w_head_y); ln = 32'(w_length);
            dd = 32'(w_dead); cw = 32'(w_collide_wall); cs = 32'(w_collide_self);
        end
        check("sb_head_x", hx, e.hx);
        check("sb_head_y", hy, e.hy);
        check("sb_length", ln, e.len);
        check("sb_dead", dd, e.dd);
        check("sb_wall", cw, e.cw);
        check("sb_self", cs, e.cs);
    endtask

    task automatic do_tick(input int d, input int g);
        @(negedge clk);
        if (sel == 0) begin tick = 1'b1; dir = 2'(d); grow = 1'(g); end
        else          begin w_tick = 1'b1; w_dir = 2'(d); w_grow = 1'(g); end
        model_step(d, g, 1);
        @(posedge clk);
        #1;
        tick = 1'b0; grow = 1'b0; w_tick = 1'b0; w_grow = 1'b0;
        check_state();
    endtask

    task automatic do_grow();
        @(negedge clk);
        if (sel == 0) grow = 1'b1; else w_grow = 1'b1;
        model_step(0, 1, 0);
        @(posedge clk);
        #1;
        grow = 1'b0; w_grow = 1'b0;
        check_state();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        model_reset((sel == 0) ? 1 : 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        exp_q.push_back('{GW / 2, GH / 2, IL, 0, 0, 0});
        check_state();
    endtask

    task automatic query(input string tag, input int x, input int y, input int exp);
        qx = XB'(x);
        qy = YB'(y);
        #1;
        check(tag, 32'(query_hit), exp);
    endtask

    initial begin
        reset = 1'b1;
        tick = 1'b0; grow = 1'b0; dir = 2'd1;
        w_tick = 1'b0; w_grow = 1'b0; w_dir = 2'd1;
        qx = '0; qy = '0; w_qx = '0; w_qy = '0;
        model_reset(1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;

        // Reset state and occupancy
        check("rst_head_x", 32'(head_x), 4);
        check("rst_head_y", 32'(head_y), 4);
        check("rst_length", 32'(length), 3);
        check("rst_dead", 32'(dead), 0);
        query("q_3_4", 3, 4, 1);
        query("q_2_4", 2, 4, 1);
        query("q_1_4", 1, 4, 0);
        query("q_4_4", 4, 4, 1);

        // Reversal rejected, then wrap right and up
        do_tick(3, 0);
        check("rev_head_x", 32'(head_x), 5);
        do_tick(3, 0);
        do_tick(1, 0);
        do_tick(1, 0);
        check("wrap_x", 32'(head_x), 0);
        for (int i = 0; i < 4; i++) do_tick(0, 0);
        check("top_y", 32'(head_y), 0);
        do_tick(0, 0);
        check("wrap_y", 32'(head_y), 7);

        // Grow with same-cycle tick, then saturate at MAX_LEN
        sel = 0;
        do_reset();
        do_tick(1, 1);
        check("grow_len", 32'(length), 4);
        query("grow_q_2_4", 2, 4, 1);
        query("grow_q_1_4", 1, 4, 0);
        for (int i = 0; i < 4; i++) do_tick(1, 1);
        check("len_max", 32'(length), 8);
        do_tick(2, 1);
        check("len_sat", 32'(length), 8);
        check("sat_head_y", 32'(head_y), 5);

        // Self collision
        do_reset();
        do_tick(1, 1);
        do_tick(1, 1);
        do_tick(2, 0);
        do_tick(3, 0);
        do_tick(0, 0);
        check("self_dead", 32'(dead), 1);
        check("self_flag", 32'(collide_self), 1);
        check("self_wall", 32'(collide_wall), 0);
        check("self_hx", 32'(head_x), 5);
        check("self_hy", 32'(head_y), 5);
        do_tick(1, 1);
        do_grow();
        check("dead_len", 32'(length), 5);

        // Tail chase after saturating grow_pend, then async reset mid-move
        do_reset();
        do_grow();
        do_grow();
        do_tick(1, 0);
        check("pend_len", 32'(length), 4);
        do_tick(2, 0);
        do_tick(3, 0);
        do_tick(0, 0);
        check("chase_hx", 32'(head_x), 4);
        check("chase_hy", 32'(head_y), 4);
        check("chase_dead", 32'(dead), 0);
        query("chase_q_5_5", 5, 5, 1);
        @(negedge clk);
        tick = 1'b1; dir = 2'd1;
        #2;
        reset = 1'b1;
        #1;
        check("arst_hx", 32'(head_x), 4);
        check("arst_hy", 32'(head_y), 4);
        check("arst_len", 32'(length), 3);
        check("arst_dead", 32'(dead), 0);
        query("arst_q_5_5", 5, 5, 0);
        @(negedge clk);
        tick = 1'b0;
        reset = 1'b0;
        #1;
        check("arst_hold_hx", 32'(head_x), 4);

        // Wall death on the non-wrapping instance
        sel = 1;
        do_reset();
        for (int i = 0; i < 3; i++) do_tick(1, 0);
        check("w_edge_x", 32'(w_head_x), 7);
        do_tick(1, 0);
        check("w_dead", 32'(w_dead), 1);
        check("w_wall", 32'(w_collide_wall), 1);
        check("w_self", 32'(w_collide_self), 0);
        check("w_hx", 32'(w_head_x), 7);
        check("w_hy", 32'(w_head_y), 4);
        do_tick(2, 1);
        do_tick(1, 0);
        check("w_len", 32'(w_length), 3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
